// File: rtl/parport_pkg.sv
// parport_pkg: shared FSM state type and default timing for the parallel-port controller
package parport_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_BUSY} state_e;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_SETUP_CYC   = 16;
  localparam int DEF_STROBE_CYC  = 32;
  localparam int DEF_HOLD_CYC    = 16;
  localparam int DEF_TIMEOUT_CYC = 32000000;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/parport_fifo.sv
// parport_fifo: power-of-two transmit FIFO with occupancy count
module parport_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk32_i,
  input  logic                       reset_n_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] level_q;
  logic push, pull;
  assign wr_ready_o = level_q != (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign head_o = mem_q[rd_ptr_q];
  assign push = wr_valid_i && wr_ready_o;
  assign pull = pop_i && !empty_o;
  always_ff @(posedge clk32_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pull) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pull);
    end
  end
  always_ff @(posedge clk32_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/parport_ctrl.sv
// parport_ctrl: Centronics-style parallel port, FIFO-fed printer output plus strobe-driven capture
module parport_ctrl
  import parport_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk32,
  input  logic                          reset_n,
  input  logic                          mode,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout,
  input  logic                          clr_timeout,
  output logic [DATA_W-1:0]             pp_data_out,
  input  logic [DATA_W-1:0]             pp_data_in,
  output logic                          pp_data_oe,
  output logic                          pp_strobe_out,
  input  logic                          pp_strobe_in,
  output logic                          pp_strobe_oe,
  input  logic                          pp_busy
);
  localparam int CW = $clog2(max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, TIMEOUT_CYC)) + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] busy_sync_q, strb_sync_q;
  logic strb_prev_q, avail_q, strobe_q, rd_valid_q, timeout_q;
  logic [DATA_W-1:0] data_q, rd_data_q, head;
  logic fifo_empty, pop, set_to, busy_s, strb_s, cnt_zero, cap;
  parport_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk32_i(clk32), .reset_n_i(reset_n), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .pop_i(pop), .head_o(head), .empty_o(fifo_empty), .level_o(fifo_level)
  );
  assign busy_s = busy_sync_q[1];
  assign strb_s = strb_sync_q[1];
  assign cnt_zero = cnt_q == '0;
  assign cap = state_q == IDLE && mode && strb_prev_q && !strb_s;
  // Mode only switches in IDLE, so any active transfer keeps the drivers on
  assign pp_data_oe = state_q != IDLE || !mode;
  assign pp_strobe_oe = pp_data_oe;
  assign pp_data_out = data_q;
  assign pp_strobe_out = strobe_q;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign timeout = timeout_q;
  always_comb begin
    state_d = state_q;
    cnt_d = state_q == IDLE ? cnt_q : cnt_q - CW'(1);
    pop = 1'b0;
    set_to = 1'b0;
    unique case (state_q)
      IDLE: if (!mode && avail_q && !busy_s) begin
        state_d = SETUP;
        cnt_d = CW'(SETUP_CYC - 1);
        pop = 1'b1;
      end
      SETUP: if (cnt_zero) begin
        state_d = STROBE;
        cnt_d = CW'(STROBE_CYC - 1);
      end
      STROBE: if (cnt_zero) begin
        state_d = HOLD;
        cnt_d = CW'(HOLD_CYC - 1);
      end
      HOLD: if (cnt_zero) begin
        state_d = WAIT_BUSY;
        cnt_d = CW'(TIMEOUT_CYC - 1);
      end
      WAIT_BUSY: if (!busy_s || cnt_zero) begin
        state_d = IDLE;
        set_to = busy_s;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_sync_q <= 2'b00;
      strb_sync_q <= 2'b11;
      strb_prev_q <= 1'b1;
      avail_q <= 1'b0;
      strobe_q <= 1'b1;
      data_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_sync_q <= {busy_sync_q[0], pp_busy};
      strb_sync_q <= {strb_sync_q[0], pp_strobe_in};
      strb_prev_q <= strb_s;
      // Registered availability and strobe give the fixed 3 + SETUP_CYC push-to-strobe latency
      avail_q <= !fifo_empty && !pop;
      strobe_q <= state_q != STROBE;
      if (pop) data_q <= head;
      if (cap) rd_data_q <= pp_data_in;
      rd_valid_q <= cap;
      timeout_q <= set_to || (timeout_q && !clr_timeout);
    end
  end
endmodule

// File: tb/tb_parport_ctrl.sv
// tb_parport_ctrl: directed checks of output timing, FIFO full, timeout, capture and reset abort
module tb_parport_ctrl;
  import parport_pkg::*;
  logic clk32 = 1'b0, reset_n, mode, wr_valid, clr_timeout, pp_strobe_in, pp_busy;
  logic [7:0] wr_data, pp_data_in, rd_data, pp_data_out;
  logic wr_ready, rd_valid, timeout, pp_data_oe, pp_strobe_out, pp_strobe_oe;
  logic [4:0] fifo_level;
  int compared = 0, mismatched = 0, lows, pulses;
  logic [7:0] got;
  parport_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk32(clk32), .reset_n(reset_n), .mode(mode), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
    .timeout(timeout), .clr_timeout(clr_timeout), .pp_data_out(pp_data_out),
    .pp_data_in(pp_data_in), .pp_data_oe(pp_data_oe), .pp_strobe_out(pp_strobe_out),
    .pp_strobe_in(pp_strobe_in), .pp_strobe_oe(pp_strobe_oe), .pp_busy(pp_busy)
  );
  always #5 clk32 = ~clk32;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk32);
      @(negedge clk32);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_chk(input logic [7:0] b, input logic busy_mid);
    wr_data = b;
    wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    step(1);
    chk("lvl_after_push", 32'(fifo_level), 1);
    step(1);
    chk("lvl_after_pop", 32'(fifo_level), 0);
    chk("data_setup", 32'(pp_data_out), 32'(b));
    pp_busy = busy_mid;
    step(16);
    chk("strobe_hi_c18", 32'(pp_strobe_out), 1);
    step(1);
    chk("strobe_lo_c19", 32'(pp_strobe_out), 0);
    step(31);
    chk("strobe_lo_c50", 32'(pp_strobe_out), 0);
    step(1);
    chk("strobe_hi_c51", 32'(pp_strobe_out), 1);
    step(14);
    chk("data_hold_end", 32'(pp_data_out), 32'(b));
  endtask
  task automatic reset_chk();
    reset_n = 1'b0;
    step(1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_strobe", 32'(pp_strobe_out), 1);
    chk("rst_data", 32'(pp_data_out), 0);
    chk("rst_rdvalid", 32'(rd_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    mode = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    clr_timeout = 1'b0;
    pp_strobe_in = 1'b1;
    pp_busy = 1'b0;
    pp_data_in = '0;
    step(2);
    chk("rst_rddata", 32'(rd_data), 0);
    chk("rst_oe", 32'(pp_data_oe), 1);
    reset_chk();
    step(2);
    send_chk(8'h41, 1'b0);
    step(10);
    pp_busy = 1'b1;
    step(3);
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      step(1);
    end
    chk("full_level", 32'(fifo_level), 16);
    chk("full_ready", 32'(wr_ready), 0);
    wr_data = 8'h10;
    step(1);
    wr_valid = 1'b0;
    chk("full_level_17", 32'(fifo_level), 16);
    lows = 0;
    repeat (40) begin
      step(1);
      if (!pp_strobe_out) lows++;
    end
    chk("busy_no_strobe", 32'(lows), 0);
    pp_busy = 1'b0;
    reset_chk();
    step(2);
    mode = 1'b1;
    step(1);
    chk("in_data_oe", 32'(pp_data_oe), 0);
    chk("in_strobe_oe", 32'(pp_strobe_oe), 0);
    pp_data_in = 8'hA5;
    pp_strobe_in = 1'b0;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) pp_strobe_in = 1'b1;
      step(1);
      if (rd_valid) begin
        pulses++;
        got = rd_data;
      end
    end
    chk("in_pulses", 32'(pulses), 1);
    chk("in_rddata", 32'(got), 32'hA5);
    mode = 1'b0;
    step(2);
    send_chk(8'h5A, 1'b1);
    step(100);
    chk("to_c99", 32'(timeout), 0);
    step(1);
    chk("to_c100", 32'(timeout), 1);
    step(3);
    chk("to_sticky", 32'(timeout), 1);
    clr_timeout = 1'b1;
    step(1);
    clr_timeout = 1'b0;
    chk("to_cleared", 32'(timeout), 0);
    pp_busy = 1'b0;
    step(3);
    send_chk(8'h3C, 1'b0);
    step(10);
    wr_data = 8'h77;
    wr_valid = 1'b1;
    step(1);
    wr_data = 8'h78;
    step(1);
    wr_valid = 1'b0;
    step(24);
    chk("abort_strobe_lo", 32'(pp_strobe_out), 0);
    chk("abort_level_pre", 32'(fifo_level), 1);
    reset_n = 1'b0;
    step(1);
    chk("abort_strobe_hi", 32'(pp_strobe_out), 1);
    chk("abort_level", 32'(fifo_level), 0);
    chk("abort_idle", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    lows = 0;
    repeat (40) begin
      step(1);
      if (!pp_strobe_out) lows++;
    end
    chk("abort_no_retry", 32'(lows), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
